button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, number of event channels; legal range 2..16.
REQ-002 Derived constant: ID_W = clog2(WIDTH), the width of event_id.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 event_pulse  input  WIDTH  one-cycle edge pulses from edge detector outputs, one bit per channel.
REQ-006 mask  input  WIDTH  per-channel enable; 1 = channel accepted, 0 = pulses on that channel ignored.
REQ-007 event_ready  input  1  consumer accepts the presented event.
REQ-008 clear_overflow  input  1  clears the sticky overflow flag.
REQ-009 event_valid  output  1  an event is presented on event_id.
REQ-010 event_id  output  ID_W  index of the channel whose event is presented.
REQ-011 pending  output  WIDTH  per-channel captured-but-not-yet-presented events.
REQ-012 overflow  output  1  sticky flag: at least one pulse was merged or lost.

Function
REQ-013 Capture: a channel pulse is accepted when event_pulse[i]=1 and mask[i]=1 at a rising edge; pending[i] is set at that edge.
REQ-014 Output slot: event_valid/event_id form a one-entry register; the slot is free when event_valid=0, or when event_valid=1 and event_ready=1 in the same cycle.
REQ-015 Grant: when the slot is free and any pending bit is 1, one channel is granted.
  - The granted ID loads into event_id.
  - event_valid is set.
  - The granted channel's pending bit clears.
  - All three happen at the same edge.
REQ-016 Round-robin: the search starts at (last_grant+1) mod WIDTH and proceeds upward with wrap-around; the first pending channel found wins; last_grant updates only on a grant.
REQ-017 Latency: a pulse accepted at edge k gives event_valid=1 after edge k+1 if the slot is free and no other channel wins; there is no combinational path from event_pulse to the outputs.
REQ-018 Throughput: with event_ready held at 1, one event is presented per cycle while any pending bit is set.
REQ-019 Hold: while event_valid=1 and event_ready=0, event_id and event_valid stay stable and no grant occurs.
REQ-020 Drain: when event_valid=1, event_ready=1 and no bit is pending, event_valid clears at the next edge.
REQ-021 Simultaneous grant and pulse: if pending[i] is granted and channel i pulses at the same edge, pending[i] stays 1 and overflow is not set.
REQ-022 Merge: a channel i pulse that is accepted while pending[i]=1 and channel i is not being granted that edge merges into the existing pending bit, and overflow is set.
REQ-023 A pulse on the channel currently held in the output slot is not a merge; it sets pending[i] normally.
REQ-024 Overflow: overflow is sticky until clear_overflow=1; if a set and clear_overflow=1 occur at the same edge, the set wins (overflow=1).
REQ-025 Masking: mask only gates new captures; pending bits already set are still granted after their mask bit drops.
REQ-026 ignored bits: event_ready while event_valid=0 has no effect.

Reset
REQ-027 When rst=1 at an edge, the following take the values listed, regardless of other inputs:
  - pending = 0
  - event_valid = 0
  - event_id = 0
  - overflow = 0
  - last_grant = WIDTH-1, so channel 0 has top priority after reset
REQ-028 Pulses sampled while rst=1 are discarded; an event presented but unaccepted when reset asserts is dropped.
REQ-029 The first capture is possible at the first edge with rst=0.

Verification (WIDTH=4, mask=4'b1111 unless noted)
REQ-030 Reset: rst=1 for 2 cycles with event_pulse=4'b1111 -> pending=0, event_valid=0, overflow=0, and no event appears after release.
REQ-031 Single event: event_pulse=4'b0100 at edge k, event_ready=1 -> after edge k+1: event_valid=1, event_id=2, pending=0; after edge k+2: event_valid=0.
REQ-032 Round-robin:
  - Step 1: event_pulse=4'b1011 at one edge, event_ready=1 -> event_id sequence 0,1,3 on consecutive cycles.
  - Step 2: event_pulse=4'b1001 -> event_id sequence 0,3.
REQ-033 Backpressure and merge:
  - Step 1: event_id=1 is held with event_ready=0 for 5 cycles -> event_id stays 1.
  - Step 2: a pulse on channel 1 -> pending=4'b0010, overflow=0.
  - Step 3: a second pulse on channel 1 -> overflow=1.
  - Step 4: event_ready=1 -> event_id=1 is presented twice in total, not three times.
REQ-034 Overflow clear: clear_overflow=1 at the same edge as a merging pulse -> overflow=1; clear_overflow=1 alone at the next edge -> overflow=0.
REQ-035 Mask and reset mid-operation:
  - Step 1: mask=4'b1110 with event_pulse=4'b0001 -> no capture.
  - Step 2: pending=4'b0110 and event_valid=1, then rst=1 for one cycle -> all outputs 0.
  - Step 3: event_pulse=4'b1000 -> event_id=3 presented.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: captures masked edge pulses per channel and presents them one at a time
// through a single output slot, granting pending channels in round-robin order.
module button_event_arbiter #(
  parameter int WIDTH = 4,
  localparam int ID_W = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIDTH-1:0] i_event_pulse,
  input  logic [WIDTH-1:0] i_mask,
  input  logic            i_event_ready,
  input  logic            i_clear_overflow,
  output logic            o_event_valid,
  output logic [ID_W-1:0] o_event_id,
  output logic [WIDTH-1:0] o_pending,
  output logic            o_overflow
);
  logic [WIDTH-1:0] r_pending;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last;
  logic             r_overflow;
  logic             w_free;
  logic             w_found;
  logic             w_grant;
  logic             w_merge;
  logic [ID_W-1:0]  w_j;
  logic [ID_W-1:0]  w_gid;
  logic [WIDTH-1:0] w_cap;
  logic [WIDTH-1:0] w_gmask;
  // first pending channel at or after last_grant+1, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gid = '0;
    w_j = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      w_j = ID_W'((int'(r_last) + k) % WIDTH);
      if (!w_found && r_pending[w_j]) begin
        w_found = 1'b1;
        w_gid = w_j;
      end
    end
  end
  assign w_free  = !r_valid || i_event_ready;
  assign w_grant = w_free && w_found;
  assign w_cap   = i_event_pulse & i_mask;
  assign w_gmask = w_grant ? (WIDTH'(1) << w_gid) : '0;
  // a capture onto a still-pending bit that is not leaving this edge loses a pulse
  assign w_merge = |(w_cap & r_pending & ~w_gmask);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_last     <= ID_W'(WIDTH - 1);
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= (r_pending & ~w_gmask) | w_cap;
      r_valid    <= w_grant || (r_valid && !i_event_ready);
      r_overflow <= w_merge || (r_overflow && !i_clear_overflow);
      if (w_grant) begin
        r_id   <= w_gid;
        r_last <= w_gid;
      end
    end
  end
  assign o_event_valid = r_valid;
  assign o_event_id    = r_id;
  assign o_pending     = r_pending;
  assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed scenarios plus random traffic, checked against a
// cycle-level reference model of the arbiter's capture/grant/overflow rules.
module tb_button_event_arbiter;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pulse = '0;
  logic [W-1:0] mask = '1;
  logic         ready = 1'b0;
  logic         clr = 1'b0;
  logic         valid;
  logic [1:0]   id;
  logic [W-1:0] pend;
  logic         ovf;
  int n_chk = 0;
  int n_fail = 0;
  bit m_pend[W];
  bit m_valid;
  int m_id;
  int m_last;
  bit m_ovf;
  button_event_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_event_pulse(pulse), .i_mask(mask),
    .i_event_ready(ready), .i_clear_overflow(clr), .o_event_valid(valid),
    .o_event_id(id), .o_pending(pend), .o_overflow(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pend_vec();
    logic [31:0] v = 0;
    for (int i = 0; i < W; i++) v[i] = m_pend[i];
    return v;
  endfunction
  // one clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic [W-1:0] p, input logic [W-1:0] m, input logic rdy,
                      input logic c, input logic r);
    int g;
    bit lost;
    pulse = p; mask = m; ready = rdy; clr = c; rst = r;
    if (r) begin
      for (int i = 0; i < W; i++) m_pend[i] = 0;
      m_valid = 0; m_id = 0; m_last = W - 1; m_ovf = 0;
    end else begin
      g = -1;
      if (!m_valid || rdy)
        for (int k = 1; k <= W; k++)
          if (g < 0 && m_pend[(m_last + k) % W]) g = (m_last + k) % W;
      lost = 0;
      for (int i = 0; i < W; i++)
        if (p[i] && m[i] && m_pend[i] && i != g) lost = 1;
      if (g >= 0) begin
        m_pend[g] = 0; m_valid = 1; m_id = g; m_last = g;
      end else if (rdy) m_valid = 0;
      for (int i = 0; i < W; i++) if (p[i] && m[i]) m_pend[i] = 1;
      m_ovf = lost || (m_ovf && !c);
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("id", 32'(id), 32'(m_id));
    chk("pending", 32'(pend), pend_vec());
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask
  initial begin
    // reset with all pulses high; nothing may survive
    step(4'b1111, 4'b1111, 1, 0, 1);
    step(4'b1111, 4'b1111, 1, 0, 1);
    chk("rst_pending", 32'(pend), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rst_no_event", 32'(valid), 0);
    // single event
    step(4'b0100, 4'b1111, 1, 0, 0);
    chk("single_cap", 32'(pend), 32'h4);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("single_valid", 32'(valid), 1);
    chk("single_id", 32'(id), 2);
    chk("single_pend", 32'(pend), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("single_drain", 32'(valid), 0);
    // round robin from a fresh reset
    step(4'b0000, 4'b1111, 1, 0, 1);
    step(4'b1011, 4'b1111, 1, 0, 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rr_a0", 32'(id), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rr_a1", 32'(id), 1);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rr_a2", 32'(id), 3);
    step(4'b1001, 4'b1111, 1, 0, 0);
    chk("rr_a_drain", 32'(valid), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rr_b0", 32'(id), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("rr_b1", 32'(id), 3);
    step(4'b0000, 4'b1111, 1, 0, 0);
    // backpressure and merge on channel 1
    step(4'b0010, 4'b1111, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b1111, 0, 0, 0);
      chk("hold_id", 32'(id), 1);
      chk("hold_valid", 32'(valid), 1);
    end
    step(4'b0010, 4'b1111, 0, 0, 0);
    chk("bp_pend", 32'(pend), 32'h2);
    chk("bp_ovf0", 32'(ovf), 0);
    step(4'b0010, 4'b1111, 0, 0, 0);
    chk("bp_ovf1", 32'(ovf), 1);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("bp_second_id", 32'(id), 1);
    chk("bp_second_valid", 32'(valid), 1);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("bp_no_third", 32'(valid), 0);
    // grant and pulse on the same channel at one edge
    step(4'b0100, 4'b1111, 0, 1, 0);
    step(4'b0100, 4'b1111, 0, 0, 0);
    chk("sim_pend", 32'(pend), 32'h4);
    chk("sim_ovf", 32'(ovf), 0);
    chk("sim_id", 32'(id), 2);
    // overflow clear racing a merge, then clear alone
    step(4'b0100, 4'b1111, 0, 1, 0);
    chk("clr_set_wins", 32'(ovf), 1);
    step(4'b0000, 4'b1111, 0, 1, 0);
    chk("clr_alone", 32'(ovf), 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    // masking, then reset mid-operation
    step(4'b0001, 4'b1110, 1, 0, 0);
    chk("mask_nocap", 32'(pend), 0);
    step(4'b0001, 4'b1111, 0, 0, 0);
    step(4'b0110, 4'b1111, 0, 0, 0);
    chk("mid_pend", 32'(pend), 32'h6);
    chk("mid_valid", 32'(valid), 1);
    step(4'b0000, 4'b1111, 0, 0, 1);
    chk("mid_rst_all", 32'({valid, id, pend, ovf}), 0);
    step(4'b1000, 4'b1111, 1, 0, 0);
    step(4'b0000, 4'b1111, 1, 0, 0);
    chk("post_rst_id", 32'(id), 3);
    chk("post_rst_valid", 32'(valid), 1);
    // random traffic against the model
    for (int n = 0; n < 400; n++)
      step(W'($urandom & $urandom), W'($urandom | $urandom), 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
